riio_ring_pwr_seq: RTL and testbench

Digital power-sequencing controller for the GF22FDX IO ring. It watches the asynchronous supply-good flag of the IO supply rail protected by the ring's power clamps. It steps the ring through reset release, output-driver enable and retention release in a fixed order with programmable dwell times. Power-down runs in the reverse order, and supply loss while the ring is live is trapped in a fault state. It sits in the always-on core domain next to the pad ring.

---
 rtl/riio_ring_pwr_seq.sv | 73 +++++++
 tb/tb_riio_ring_pwr_seq.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/riio_ring_pwr_seq.sv
// riio_ring_pwr_seq: IO ring power sequencer (reset release, driver enable, retention release, reverse power-down, fault trap)
module riio_ring_pwr_seq #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             vdd_ok_i,
  input  logic             pwr_req_i,
  input  logic [CNT_W-1:0] t_settle_i,
  input  logic [CNT_W-1:0] t_enable_i,
  input  logic             fault_clr_i,
  output logic             ring_rst_no,
  output logic             io_oe_en_o,
  output logic             io_ret_o,
  output logic             ready_o,
  output logic             fault_o,
  output logic [2:0]       state_o
);
  localparam logic [2:0] OFF         = 3'd0;
  localparam logic [2:0] WAIT_SUPPLY = 3'd1;
  localparam logic [2:0] SETTLE      = 3'd2;
  localparam logic [2:0] RING_ON     = 3'd3;
  localparam logic [2:0] ACTIVE      = 3'd4;
  localparam logic [2:0] DRAIN       = 3'd5;
  localparam logic [2:0] FAULT       = 3'd6;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   vdd_ok_s;
  logic [2:0]             state, nxt;
  logic [CNT_W-1:0]       cnt, t_lat;
  logic                   done;
  assign vdd_ok_s = sync_q[SYNC_STAGES-1];
  assign done = cnt == t_lat;
  // bring the asynchronous supply-good flag into the clk domain
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync_q <= '0;
    else sync_q <= {sync_q[SYNC_STAGES-2:0], vdd_ok_i};
  // next state; supply loss outranks the power request, illegal codes fall back to OFF
  always_comb begin
    nxt = OFF;
    case (state)
      OFF:         nxt = pwr_req_i ? WAIT_SUPPLY : OFF;
      WAIT_SUPPLY: nxt = !pwr_req_i ? OFF : vdd_ok_s ? SETTLE : WAIT_SUPPLY;
      SETTLE:      nxt = !vdd_ok_s ? WAIT_SUPPLY : !pwr_req_i ? OFF : done ? RING_ON : SETTLE;
      RING_ON:     nxt = !vdd_ok_s ? FAULT : !pwr_req_i ? DRAIN : done ? ACTIVE : RING_ON;
      ACTIVE:      nxt = !vdd_ok_s ? FAULT : !pwr_req_i ? DRAIN : ACTIVE;
      DRAIN:       nxt = !vdd_ok_s ? FAULT : done ? OFF : DRAIN;
      FAULT:       nxt = (fault_clr_i && !pwr_req_i) ? OFF : FAULT;
      default:     nxt = OFF;
    endcase
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= OFF;
    else state <= nxt;
  // dwell counter restarts on every state entry and parks at the latched limit so it never wraps
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt   <= '0;
      t_lat <= '0;
    end else if (nxt != state) begin
      cnt   <= '0;
      t_lat <= (nxt == SETTLE) ? t_settle_i : t_enable_i;
    end else if (!done) begin
      cnt   <= cnt + 1'b1;
    end
  assign ring_rst_no = (state == RING_ON) || (state == ACTIVE) || (state == DRAIN);
  assign io_oe_en_o  = state == ACTIVE;
  assign io_ret_o    = state != ACTIVE;
  assign ready_o     = state == ACTIVE;
  assign fault_o     = state == FAULT;
  assign state_o     = state;
endmodule

// File: tb/tb_riio_ring_pwr_seq.sv
// tb_riio_ring_pwr_seq: vector table, directed corner sequences and random run against a countdown reference model
module tb_riio_ring_pwr_seq;
  localparam int SYNC = 2;
  localparam logic [4:0] O0 = 5'b00100;
  localparam logic [4:0] O3 = 5'b10100;
  localparam logic [4:0] O4 = 5'b11010;
  localparam logic [4:0] O6 = 5'b00101;
  typedef struct {
    logic        req;
    logic [15:0] ts;
    logic [2:0]  st;
    logic [4:0]  outs;
  } vec_t;
  logic clk, rst_n, vdd, req, clr;
  logic [15:0] ts, te;
  logic ring_rst_no, io_oe_en_o, io_ret_o, ready_o, fault_o;
  logic [2:0] state_o;
  int checks = 0;
  int errors = 0;
  int m_st;
  int m_left;
  bit m_q[$];
  vec_t vq[$];
  riio_ring_pwr_seq #(.SYNC_STAGES(SYNC), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .vdd_ok_i(vdd), .pwr_req_i(req),
    .t_settle_i(ts), .t_enable_i(te), .fault_clr_i(clr),
    .ring_rst_no(ring_rst_no), .io_oe_en_o(io_oe_en_o), .io_ret_o(io_ret_o),
    .ready_o(ready_o), .fault_o(fault_o), .state_o(state_o)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  function automatic logic [4:0] outs();
    return {ring_rst_no, io_oe_en_o, io_ret_o, ready_o, fault_o};
  endfunction
  function automatic logic [4:0] m_out(int s);
    return s == 4 ? O4 : s == 6 ? O6 : (s == 3 || s == 5) ? O3 : O0;
  endfunction
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic m_reset();
    m_st = 0;
    m_left = 0;
    m_q = {};
    repeat (SYNC) m_q.push_back(1'b0);
  endtask
  // reference: supply flag delayed through a queue, dwell as a countdown of remaining extra cycles
  task automatic m_edge();
    bit vs;
    int nx;
    vs = m_q[SYNC-1];
    nx = m_st;
    case (m_st)
      0: if (req) nx = 1;
      1: if (!req) nx = 0; else if (vs) nx = 2;
      2: if (!vs) nx = 1; else if (!req) nx = 0; else if (m_left == 0) nx = 3;
      3: if (!vs) nx = 6; else if (!req) nx = 5; else if (m_left == 0) nx = 4;
      4: if (!vs) nx = 6; else if (!req) nx = 5;
      5: if (!vs) nx = 6; else if (m_left == 0) nx = 0;
      6: if (clr && !req) nx = 0;
      default: nx = 0;
    endcase
    if (nx != m_st) m_left = (nx == 2) ? int'(ts) : int'(te);
    else if (m_left > 0) m_left--;
    m_st = nx;
    m_q.push_front(vdd);
    void'(m_q.pop_back());
  endtask
  task automatic step();
    m_edge();
    @(posedge clk);
    #1;
    chk("model_state", 16'(state_o), 16'(m_st));
    chk("model_outs", 16'(outs()), 16'(m_out(m_st)));
  endtask
  task automatic expect_st(input string name, input logic [2:0] st, input logic [4:0] o);
    chk(name, 16'(state_o), 16'(st));
    chk({name, "_outs"}, 16'(outs()), 16'(o));
  endtask
  task automatic run_until(input logic [2:0] tgt, input int budget);
    int n;
    n = 0;
    while (state_o !== tgt && n < budget) begin
      step();
      n++;
    end
    chk("reach_state", 16'(state_o), 16'(tgt));
  endtask
  initial begin
    rst_n = 0; vdd = 1; req = 0; clr = 0; ts = 3; te = 2;
    m_reset();
    #3;
    expect_st("reset", 3'd0, O0);
    #9 rst_n = 1;
    repeat (3) step();
    vq.push_back('{1'b1, 16'd3, 3'd1, O0});
    repeat (4) vq.push_back('{1'b1, 16'd3, 3'd2, O0});
    repeat (3) vq.push_back('{1'b1, 16'd3, 3'd3, O3});
    repeat (2) vq.push_back('{1'b1, 16'd3, 3'd4, O4});
    repeat (2) vq.push_back('{1'b0, 16'd3, 3'd5, O3});
    vq.push_back('{1'b1, 16'd3, 3'd5, O3});
    vq.push_back('{1'b1, 16'd3, 3'd0, O0});
    vq.push_back('{1'b1, 16'd3, 3'd1, O0});
    vq.push_back('{1'b1, 16'd3, 3'd2, O0});
    repeat (3) vq.push_back('{1'b1, 16'd0, 3'd2, O0});
    repeat (3) vq.push_back('{1'b1, 16'd0, 3'd3, O3});
    vq.push_back('{1'b1, 16'd0, 3'd4, O4});
    foreach (vq[i]) begin
      req = vq[i].req;
      ts = vq[i].ts;
      step();
      expect_st($sformatf("vec%0d", i), vq[i].st, vq[i].outs);
    end
    vdd = 0;
    step(); expect_st("fault_lat1", 3'd4, O4);
    step(); expect_st("fault_lat2", 3'd4, O4);
    step(); expect_st("fault_enter", 3'd6, O6);
    clr = 1;
    repeat (3) begin step(); expect_st("fault_hold_req", 3'd6, O6); end
    vdd = 1;
    step(); expect_st("fault_hold_vdd", 3'd6, O6);
    req = 0;
    step(); expect_st("fault_clear", 3'd0, O0);
    clr = 0; ts = 0; te = 0; req = 1;
    step(); expect_st("t0_wait", 3'd1, O0);
    step(); expect_st("t0_settle", 3'd2, O0);
    step(); expect_st("t0_ring_on", 3'd3, O3);
    step(); expect_st("t0_active", 3'd4, O4);
    vdd = 0;
    step(); step();
    req = 0;
    step(); expect_st("fault_beats_drain", 3'd6, O6);
    clr = 1; vdd = 1;
    step(); expect_st("clear2", 3'd0, O0);
    clr = 0; ts = 5; te = 1; req = 1;
    run_until(3'd2, 10);
    step(); step();
    vdd = 0;
    step(); step();
    step(); expect_st("glitch_abort", 3'd1, O0);
    vdd = 1;
    step(); step(); expect_st("glitch_wait", 3'd1, O0);
    step(); expect_st("glitch_resettle", 3'd2, O0);
    repeat (5) step();
    expect_st("resettle_full", 3'd2, O0);
    step(); expect_st("resettle_done", 3'd3, O3);
    run_until(3'd4, 10);
    #2 rst_n = 0;
    #1;
    expect_st("async_reset", 3'd0, O0);
    m_reset();
    #3 rst_n = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(19) == 0) req = ~req;
      if ($urandom_range(29) == 0) vdd = ~vdd;
      clr = ($urandom_range(7) == 0);
      ts = 16'($urandom_range(4));
      te = 16'($urandom_range(4));
      step();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
